// File: rtl/bs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : bs_pkg                                                        |
// | Description : Shared types and constants for the parametrised receive-side |
// |               bit-unstuffer.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bs_pkg;

  // Unstuffer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    STRIP = 2'd2,
    ERROR = 2'd3
  } bs_state_t;

  // Classic USB full/low-speed stuffing run length
  localparam int USB_RUN_LEN = 6;

  // Width needed to count 0..run_len consecutive ones
  function automatic int ones_cnt_width(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_unstuffer_param_run_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : run_counter                                                   |
// | Description : Consecutive-ones counter. Increments on a one, clears on a   |
// |               zero or on an explicit clear, and flags when the bit being   |
// |               counted completes a run of RUN_LEN ones.                     |
// | Ports       : clock    - system clock                                      |
// |               reset_n  - asynchronous active-low reset                     |
// |               clear    - synchronous clear (priority over enable)          |
// |               enable   - count bit_in this cycle                           |
// |               bit_in   - data bit being counted                            |
// |               run_hit  - this bit is the RUN_LEN-th consecutive one        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module run_counter #(
  parameter int RUN_LEN = 6,
  parameter int CNT_W   = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic run_hit
);

  localparam logic [CNT_W-1:0] c_run_len = CNT_W'(RUN_LEN);

  logic [CNT_W-1:0] r_ones_cnt;
  logic [CNT_W-1:0] w_inc;

  // The count never exceeds RUN_LEN: the owner clears it on the stuff bit
  // that always follows a hit, so the increment cannot wrap.
  assign w_inc   = r_ones_cnt + 1'b1;
  assign run_hit = enable & bit_in & (w_inc == c_run_len);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ones_cnt <= '0;
    end else if (clear) begin
      r_ones_cnt <= '0;
    end else if (enable) begin
      r_ones_cnt <= bit_in ? w_inc : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bit_unstuffer_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bit_unstuffer_param                                           |
// | Description : Receive-side bit-unstuffer. Drops the zero stuffed after     |
// |               RUN_LEN consecutive ones, flags a stuff error when that bit  |
// |               is a one, and reports per-packet delivered-bit count and     |
// |               error status when nrzi_sending deasserts. All outputs are    |
// |               registered, one cycle after the sampled input bit.           |
// | Ports       : clock        - system clock                                  |
// |               reset_n      - asynchronous active-low reset                 |
// |               nrzi_sending - in_bit valid this cycle                       |
// |               in_bit       - decoded data bit, LSB-first                   |
// |               out_bit      - unstuffed data bit                            |
// |               bs_sending   - out_bit valid this cycle                      |
// |               stuff_err    - pulse: RUN_LEN+1 consecutive ones seen        |
// |               pkt_done     - pulse at end of packet                        |
// |               pkt_len      - delivered bits of last packet (saturating)    |
// |               pkt_err      - error status of last packet                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bit_unstuffer_param
  import bs_pkg::*;
#(
  parameter int RUN_LEN = USB_RUN_LEN,
  parameter int CNT_W   = 11
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             nrzi_sending,
  input  logic             in_bit,
  output logic             out_bit,
  output logic             bs_sending,
  output logic             stuff_err,
  output logic             pkt_done,
  output logic [CNT_W-1:0] pkt_len,
  output logic             pkt_err
);

  localparam int               c_ones_w  = ones_cnt_width(RUN_LEN);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  bs_state_t        r_state;
  bs_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic             r_err_flag;
  logic             w_err_flag_nxt;

  logic             r_out_bit;
  logic             r_bs_sending;
  logic             r_stuff_err;
  logic             r_pkt_done;
  logic [CNT_W-1:0] r_pkt_len;
  logic             r_pkt_err;

  logic             w_out_bit;
  logic             w_bs_sending;
  logic             w_stuff_err;
  logic             w_pkt_done;
  logic [CNT_W-1:0] w_pkt_len;
  logic             w_pkt_err;

  logic             w_cnt_en;
  logic             w_cnt_clr;
  logic             w_run_hit;

  run_counter #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (c_ones_w)
  ) u_run_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_cnt_clr),
    .enable  (w_cnt_en),
    .bit_in  (in_bit),
    .run_hit (w_run_hit)
  );

  // Next-state and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_err_flag_nxt = r_err_flag;
    w_out_bit      = 1'b0;
    w_bs_sending   = 1'b0;
    w_stuff_err    = 1'b0;
    w_pkt_done     = 1'b0;
    w_pkt_len      = r_pkt_len;
    w_pkt_err      = r_pkt_err;
    w_cnt_en       = 1'b0;
    w_cnt_clr      = 1'b0;

    if (!nrzi_sending) begin
      // End of packet from any active state, including STRIP: a missing
      // stuff bit at the tail is not treated as an error.
      if (r_state != IDLE) begin
        w_pkt_done     = 1'b1;
        w_pkt_len      = r_bit_cnt;
        w_pkt_err      = r_err_flag;
        w_bit_cnt_nxt  = '0;
        w_err_flag_nxt = 1'b0;
        w_cnt_clr      = 1'b1;
        w_state_nxt    = IDLE;
      end
    end else begin
      unique case (r_state)
        // IDLE handles the first bit exactly like PASS; counters are
        // already zero because every exit to IDLE clears them.
        IDLE, PASS: begin
          w_bs_sending  = 1'b1;
          w_out_bit     = in_bit;
          w_bit_cnt_nxt = (r_bit_cnt == c_cnt_max) ? r_bit_cnt : r_bit_cnt + 1'b1;
          w_cnt_en      = 1'b1;
          w_state_nxt   = w_run_hit ? STRIP : PASS;
        end
        STRIP: begin
          w_cnt_clr = 1'b1;
          if (in_bit) begin
            w_stuff_err    = 1'b1;
            w_err_flag_nxt = 1'b1;
            w_state_nxt    = ERROR;
          end else begin
            w_state_nxt = PASS;
          end
        end
        ERROR: begin
          // Swallow the rest of the packet
          w_cnt_clr = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_err_flag   <= 1'b0;
      r_out_bit    <= 1'b0;
      r_bs_sending <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_len    <= '0;
      r_pkt_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_err_flag   <= w_err_flag_nxt;
      r_out_bit    <= w_out_bit;
      r_bs_sending <= w_bs_sending;
      r_stuff_err  <= w_stuff_err;
      r_pkt_done   <= w_pkt_done;
      r_pkt_len    <= w_pkt_len;
      r_pkt_err    <= w_pkt_err;
    end
  end

  assign out_bit    = r_out_bit;
  assign bs_sending = r_bs_sending;
  assign stuff_err  = r_stuff_err;
  assign pkt_done   = r_pkt_done;
  assign pkt_len    = r_pkt_len;
  assign pkt_err    = r_pkt_err;

endmodule
`default_nettype wire

// File: tb/tb_bit_unstuffer_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bit_unstuffer_param                                        |
// | Description : Scoreboard bench for bit_unstuffer_param. dut0 uses the USB   |
// |               run length (6), dut1 uses RUN_LEN=4 with a 4-bit length      |
// |               counter. Expected events are queued as stimulus is driven    |
// |               and matched by a negedge monitor.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bit_unstuffer_param;

  typedef struct {
    int kind;  // 0 = delivered bit, 1 = stuff error, 2 = packet done
    int val;
    int len;
    int err;
  } ev_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic        nrzi0 = 1'b0, in0 = 1'b0;
  logic        ob0, bs0, se0, pd0, pe0;
  logic [10:0] len0;

  logic        nrzi1 = 1'b0, in1 = 1'b0;
  logic        ob1, bs1, se1, pd1, pe1;
  logic [3:0]  len1;

  ev_t q0[$];
  ev_t q1[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clock = ~clock;

  bit_unstuffer_param #(.RUN_LEN(6), .CNT_W(11)) dut0 (
    .clock(clock), .reset_n(reset_n), .nrzi_sending(nrzi0), .in_bit(in0),
    .out_bit(ob0), .bs_sending(bs0), .stuff_err(se0), .pkt_done(pd0),
    .pkt_len(len0), .pkt_err(pe0)
  );

  bit_unstuffer_param #(.RUN_LEN(4), .CNT_W(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .nrzi_sending(nrzi1), .in_bit(in1),
    .out_bit(ob1), .bs_sending(bs1), .stuff_err(se1), .pkt_done(pd1),
    .pkt_len(len1), .pkt_err(pe1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int sel, input int kind, input int val, input int len, input int err);
    ev_t e;
    e.kind = kind; e.val = val; e.len = len; e.err = err;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Monitor: match whatever the DUT presents against the queue head
  task automatic observe(input int sel, input logic bs, input logic ob, input logic se,
                         input logic pd, input int len, input logic pe);
    ev_t e;
    int  k, nflags;
    bit  empty;
    nflags = int'(bs) + int'(se) + int'(pd);
    if (nflags == 0) return;
    chk($sformatf("dut%0d_exclusive_flags", sel), nflags, 1);
    k = pd ? 2 : (se ? 1 : 0);
    empty = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d_unexpected_event: actual kind %0d expected none (t=%0t)", sel, k, $time);
      return;
    end
    if (sel == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    chk($sformatf("dut%0d_event_kind", sel), k, e.kind);
    if (k == e.kind) begin
      if (k == 0) chk($sformatf("dut%0d_out_bit", sel), int'(ob), e.val);
      if (k == 2) begin
        chk($sformatf("dut%0d_pkt_len", sel), len, e.len);
        chk($sformatf("dut%0d_pkt_err", sel), int'(pe), e.err);
      end
    end
  endtask

  always @(negedge clock) observe(0, bs0, ob0, se0, pd0, int'(len0), pe0);
  always @(negedge clock) observe(1, bs1, ob1, se1, pd1, int'(len1), pe1);

  task automatic set_in(input int sel, input logic v, input logic b);
    if (sel == 0) begin nrzi0 = v; in0 = b; end
    else          begin nrzi1 = v; in1 = b; end
  endtask

  // One bit per cycle; code: p = delivered, e = stuff error, d/x = no output
  task automatic drive_bit(input int sel, input byte b, input byte code);
    logic bv;
    bv = (b == "1");
    @(posedge clock); #1;
    set_in(sel, 1'b1, bv);
    if (code == "p") push_ev(sel, 0, int'(bv), 0, 0);
    if (code == "e") push_ev(sel, 1, 0, 0, 0);
  endtask

  // Whole packet followed by exactly one cycle with nrzi_sending low
  task automatic drive_pkt(input int sel, input string bits, input string exp,
                           input int len, input int err);
    for (int i = 0; i < bits.len(); i++) drive_bit(sel, bits[i], exp[i]);
    @(posedge clock); #1;
    set_in(sel, 1'b0, 1'b0);
    push_ev(sel, 2, 0, len, err);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_bit", int'(ob0), 0);
    chk("rst_bs_sending", int'(bs0), 0);
    chk("rst_stuff_err", int'(se0), 0);
    chk("rst_pkt_done", int'(pd0), 0);
    chk("rst_pkt_len", int'(len0), 0);
    chk("rst_pkt_err", int'(pe0), 0);
    chk("rst_dut1_bs_sending", int'(bs1), 0);
    chk("rst_dut1_pkt_len", int'(len1), 0);
    reset_n = 1'b1;
    idle(2);

    // Bits 6, 13, 21 are stuff zeros; 21 delivered
    drive_pkt(0, "111111011111100111111011", "ppppppdppppppdpppppppdpp", 21, 0);
    idle(3);

    // Seven ones: stuff error, remainder swallowed
    drive_pkt(0, "11111110101", "ppppppexxxx", 6, 1);
    idle(3);

    // RUN_LEN=4: both zeros after the four-one runs dropped
    drive_pkt(1, "111101111011", "ppppdppppdpp", 10, 0);
    idle(3);

    // Packet ends in STRIP: not an error
    drive_pkt(0, "111111", "pppppp", 6, 0);
    idle(3);

    // Back-to-back with a one-cycle gap: no ones carry-over, zero passed
    drive_pkt(0, "111", "ppp", 3, 0);
    drive_pkt(0, "11110", "ppppp", 5, 0);
    idle(3);

    // Saturation of the 4-bit length counter on dut1
    drive_pkt(1, "00000000000000000000", "pppppppppppppppppppp", 15, 0);
    idle(3);

    // Reset mid-packet after 10 bits
    for (int i = 0; i < 10; i++) drive_bit(0, (i % 2 == 1) ? "1" : "0", "p");
    @(posedge clock);
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_bit", int'(ob0), 0);
    chk("midrst_bs_sending", int'(bs0), 0);
    chk("midrst_stuff_err", int'(se0), 0);
    chk("midrst_pkt_done", int'(pd0), 0);
    chk("midrst_pkt_len", int'(len0), 0);
    chk("midrst_pkt_err", int'(pe0), 0);
    chk("midrst_dut1_pkt_len", int'(len1), 0);
    @(posedge clock); @(posedge clock); #1;
    set_in(0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    drive_pkt(0, "00000000", "pppppppp", 8, 0);
    idle(5);

    chk("dut0_queue_drained", q0.size(), 0);
    chk("dut1_queue_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
